// File: rtl/logic_clock_domain_crossing_generic_write.sv
`default_nettype none
// ============================================================================
// Module      : logic_clock_domain_crossing_generic_write
// Description : Write-side controller of the generic dual-clock FIFO. Accepts
//               an AXI4-Stream-style rx stream, drives the storage write port
//               and advances the binary write pointer. Full is derived from a
//               read pointer already synchronized into the rx domain.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_clock_domain_crossing_generic_write #(
    parameter int DATA_WIDTH    = 1,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     rx_aclk,
    input  logic                     rx_areset,
    input  logic                     rx_tvalid,
    input  logic [DATA_WIDTH-1:0]    rx_tdata,
    output logic                     rx_tready,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_pointer_synced
);

    // Margin that absorbs the two-cycle lag of almost_full behind the pointers.
    localparam int ALMOST_FULL = 2;
    localparam logic [ADDRESS_WIDTH-1:0] AF_THRESHOLD =
        ADDRESS_WIDTH'((2 ** ADDRESS_WIDTH) - 1 - ALMOST_FULL);
    localparam logic [ADDRESS_WIDTH-1:0] POINTER_STEP = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] DIFF_MAX     = '1;
    localparam logic [ADDRESS_WIDTH-1:0] DIFF_ZERO    = '0;

    // The 3-bit exact full compare below needs at least 3 pointer bits.
    generate
        if (ADDRESS_WIDTH < 3) begin : g_address_width_check
            $error("ADDRESS_WIDTH must be at least 3");
        end
    endgenerate

    logic [ADDRESS_WIDTH-1:0] difference;
    logic                     almost_full;
    logic                     full;
    logic [ADDRESS_WIDTH-1:0] pointer_plus_one;

    // Fill level (registered) and the coarse near-full flag derived from it.
    // almost_full resets high so the exact compare decides until levels settle.
    always_ff @(posedge rx_aclk or posedge rx_areset) begin
        if (rx_areset) begin
            difference  <= '0;
            almost_full <= 1'b1;
        end else begin
            difference  <= write_pointer - read_pointer_synced;
            almost_full <= (difference >= AF_THRESHOLD);
        end
    end

    // Exact full: only trusted while almost_full says the level is near the
    // top, where the true level lies within 8 of the threshold so 3 bits of
    // the pointers are enough to resolve it. Uses the live read pointer so a
    // freed slot re-opens rx_tready in the same cycle.
    always_comb begin
        pointer_plus_one = write_pointer + POINTER_STEP;
        full             = almost_full &&
                           (pointer_plus_one[2:0] == read_pointer_synced[2:0]);
        rx_tready        = !full;
        write_enable     = rx_tvalid && rx_tready;
        write_data       = rx_tdata;
    end

    // Binary write pointer, doubling as this cycle's storage address; wraps
    // naturally.
    always_ff @(posedge rx_aclk or posedge rx_areset) begin
        if (rx_areset) begin
            write_pointer <= '0;
        end else if (write_enable) begin
            write_pointer <= pointer_plus_one;
        end
    end

`ifdef OVL_ASSERT_ON
    logic monitor_reset_n;
    assign monitor_reset_n = ~rx_areset;

    // Level wrapping from completely full straight to empty means overflow.
    ovl_no_transition #(
        .width (ADDRESS_WIDTH),
        .msg   ("write side overflow")
    ) u_overflow_check (
        .clock       (rx_aclk),
        .reset       (monitor_reset_n),
        .enable      (1'b1),
        .test_expr   (difference),
        .start_state (DIFF_MAX),
        .next_state  (DIFF_ZERO),
        .fire        ()
    );

    // Level wrapping from empty straight to completely full means underflow.
    ovl_no_transition #(
        .width (ADDRESS_WIDTH),
        .msg   ("write side underflow")
    ) u_underflow_check (
        .clock       (rx_aclk),
        .reset       (monitor_reset_n),
        .enable      (1'b1),
        .test_expr   (difference),
        .start_state (DIFF_ZERO),
        .next_state  (DIFF_MAX),
        .fire        ()
    );
`endif

endmodule
`default_nettype wire
